miriscv_data_mem: RTL and testbench
===================================

# miriscv_data_mem

Data-memory slave that sits directly downstream of the core's load/store unit and answers its memory protocol (req / we / be / addr / wdata → rdata / ready). Holds a word-organised RAM with per-byte write enables, inserts a programmable number of wait states per access, and returns a one-cycle ready pulse that releases the LSU stall. Out-of-range addresses complete normally but are flagged and have no side effects.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 4..65536.
- WAIT_CYCLES, 2: wait states inserted between acceptance and response; 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; 4-byte aligned.
- clk_i  in  1  single clock, all state updates on rising edge.
- arstn_i  in  1  reset, synchronous, active-high.
- mem_req_i  in  1  access request; held by the LSU until mem_ready_o.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_be_i  in  4  byte enables for writes; bit i selects wdata[8i+7:8i]; ignored on reads.
- mem_addr_i  in  32  byte address; bits [1:0] ignored.
- mem_wdata_i  in  32  write data, already lane-replicated by the LSU.
- mem_rdata_o  out  32  read data, valid while mem_ready_o=1 after a read.
- mem_ready_o  out  1  one-cycle completion pulse.
- mem_err_o  out  1  high with mem_ready_o when the access was out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: mem_req_i=1 at a rising edge → latch we, be, addr, wdata; go WAIT with wait counter = WAIT_CYCLES−1 if WAIT_CYCLES>0, else perform the access at this edge and go RESP.
- WAIT: inputs ignored (mem_req_i may change or drop; transaction still completes with latched values). Counter decrements each edge; at the edge where counter==0, perform the access and go RESP.
- RESP: mem_ready_o=1 for exactly this cycle; mem_err_o valid; next state IDLE unconditionally. A request present during RESP is not accepted; it is accepted in the following IDLE cycle.
- Address decode: offset = addr − BASE_ADDR (32-bit, unsigned). In range iff offset < 4·DEPTH_WORDS. Word index = offset[log2(DEPTH_WORDS)+1:2].
- Write, in range: for each i with be[i]=1, RAM[idx] byte i ← wdata byte i; other bytes unchanged. be=4'b0000 is a legal no-op write that still completes.
- Read, in range: mem_rdata_o ← RAM[idx] (full word; LSU extracts/extends).
- Out of range: writes discarded, reads return 32'h0, mem_err_o=1 in RESP.
- mem_rdata_o is a register: updated only by reads, holds its value across writes and idle cycles.
- RAM contents are not cleared by reset; undefined until written.

## Timing
- Reset (arstn_i=1 at an edge): state IDLE, counter 0, mem_ready_o=0, mem_err_o=0, mem_rdata_o=32'h0. Reset wins over every other event in that cycle.
- Reset mid-WAIT: transaction abandoned, no RAM update, no ready pulse. Reset in RESP: pulse truncated, RAM already updated stays updated.
- Latency: request accepted in IDLE cycle c → mem_ready_o high in cycle c+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles (accept, waits, RESP) when req is held continuously.
- Read-after-write to the same word, back-to-back: read returns the newly written data (write commits before RESP of the write).
- mem_ready_o never high for two consecutive cycles; never high without a preceding accepted request.

## Test plan
- Reset then idle 5 cycles with req=0 → mem_ready_o=0, mem_err_o=0, mem_rdata_o=0 throughout.
- WAIT_CYCLES=2: write addr 0x10, be=1111, wdata 0xDEADBEEF accepted cycle 0 → ready only in cycle 3; then read 0x10 → rdata 0xDEADBEEF with ready 3 cycles after acceptance.
- Byte/half lanes: write 0x11223344 to 0x20, then be=0010 wdata 0xAAAAAAAA to 0x21, be=1100 wdata 0x55665566 to 0x22 → read 0x20 returns 0x5566AA44.
- Out of range (DEPTH_WORDS=256): write 0xFFFFFFFF to 0x400 → ready with err=1; read 0x400 → rdata 0, err=1; read 0x000 unchanged.
- Drop req during WAIT after a write to 0x30 → ready still pulses once, RAM[0x30] updated; req held through RESP → second access accepted the cycle after RESP, not in RESP.
- arstn_i=1 during WAIT of a write to 0x40 (previously 0x12345678) → no ready pulse, read of 0x40 returns 0x12345678; WAIT_CYCLES=0 variant → ready in cycle after acceptance.

Source files
------------

// File: rtl/miriscv_data_mem.sv
// miriscv_data_mem: word-organised data RAM slave for the LSU with programmable wait states
module miriscv_data_mem #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_err_o
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            accept, acc;
    logic            we_q, ok_q, err_q;
    logic [3:0]      be_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     offset;
    logic            in_ok;
    logic [AW-1:0]   in_idx;
    logic            acc_we, acc_ok;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [31:0]     ram [DEPTH_WORDS];

    assign offset = mem_addr_i - BASE_ADDR;
    assign in_ok  = offset < SPAN;
    assign in_idx = offset[AW+1:2];

    // With zero wait states the access happens at the accepting edge, so take the live inputs
    assign acc_we    = (state == IDLE) ? mem_we_i    : we_q;
    assign acc_ok    = (state == IDLE) ? in_ok       : ok_q;
    assign acc_be    = (state == IDLE) ? mem_be_i    : be_q;
    assign acc_idx   = (state == IDLE) ? in_idx      : idx_q;
    assign acc_wdata = (state == IDLE) ? mem_wdata_i : wdata_q;

    assign mem_ready_o = state == RESP;
    assign mem_err_o   = (state == RESP) && err_q;

    // Next-state logic: accept in IDLE, count down wait states, perform access on the last one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        acc       = 1'b0;
        case (state)
            IDLE: if (mem_req_i) begin
                accept = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    acc       = 1'b1;
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_INIT;
                end
            end
            WAIT: if (cnt == 4'd0) begin
                acc       = 1'b1;
                state_nxt = RESP;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request latch and registered read response
    always_ff @(posedge clk_i) begin
        if (arstn_i) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            err_q       <= 1'b0;
            mem_rdata_o <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= mem_we_i;
                be_q    <= mem_be_i;
                idx_q   <= in_idx;
                ok_q    <= in_ok;
                wdata_q <= mem_wdata_i;
            end
            if (acc) begin
                err_q <= !acc_ok;
                if (!acc_we)
                    mem_rdata_o <= acc_ok ? ram[acc_idx] : 32'h0;
            end
        end
    end

    // Byte-masked RAM write; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (!arstn_i && acc && acc_we && acc_ok)
            for (int i = 0; i < 4; i++)
                if (acc_be[i])
                    ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb_miriscv_data_mem: directed self-checking bench for the data memory slave
module tb_miriscv_data_mem;
    logic        clk, arstn;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err;
    logic        req0, we0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] got_rdata;
    logic        got_err;

    miriscv_data_mem #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk_i(clk), .arstn_i(arstn), .mem_req_i(req), .mem_we_i(we), .mem_be_i(be),
        .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_rdata_o(rdata),
        .mem_ready_o(ready), .mem_err_o(err)
    );

    miriscv_data_mem #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk_i(clk), .arstn_i(arstn), .mem_req_i(req0), .mem_we_i(we0), .mem_be_i(be0),
        .mem_addr_i(addr0), .mem_wdata_i(wdata0), .mem_rdata_o(rdata0),
        .mem_ready_o(ready0), .mem_err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access starting just after a rising edge, check latency and single-cycle ready
    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                          input string tag);
        int n;
        n = 0;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ready && n < 20);
        check({tag, "_lat"}, 32'(n), 32'd3);
        got_rdata = rdata;
        got_err   = err;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0;
        @(negedge clk);
        check({tag, "_pulse1"}, {31'h0, ready}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses, first;
        arstn = 1'b1;
        req = 0; we = 0; be = 0; addr = 0; wdata = 0;
        req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wdata0 = 0;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_outs", {rdata[29:0], ready, err}, 32'h0);
        end
        @(posedge clk);
        #1;
        access(1'b1, 4'hF, 32'h0, 32'hCAFEF00D, "w0");
        access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "w10");
        check("w10_err", {31'h0, got_err}, 32'h0);
        access(1'b0, 4'h0, 32'h10, 32'h0, "r10");
        check("r10_data", got_rdata, 32'hDEADBEEF);
        check("r10_err", {31'h0, got_err}, 32'h0);
        access(1'b1, 4'hF, 32'h20, 32'h11223344, "w20");
        access(1'b1, 4'h2, 32'h21, 32'hAAAAAAAA, "w21");
        access(1'b1, 4'hC, 32'h22, 32'h55665566, "w22");
        access(1'b0, 4'h0, 32'h20, 32'h0, "r20");
        check("r20_data", got_rdata, 32'h5566AA44);
        access(1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, "woor");
        check("woor_err", {31'h0, got_err}, 32'h1);
        check("woor_hold", got_rdata, 32'h5566AA44);
        access(1'b0, 4'h0, 32'h400, 32'h0, "roor");
        check("roor_data", got_rdata, 32'h0);
        check("roor_err", {31'h0, got_err}, 32'h1);
        access(1'b0, 4'h0, 32'h0, 32'h0, "r0");
        check("r0_data", got_rdata, 32'hCAFEF00D);
        check("r0_err", {31'h0, got_err}, 32'h0);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'hA5A50F0F;
        pulses = 0;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            if (k == 1) begin
                #1 req = 1'b0; we = 1'b0;
            end
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("drop_pulses", 32'(pulses), 32'd1);
        check("drop_lat", 32'(first), 32'd3);
        @(posedge clk);
        #1;
        access(1'b0, 4'h0, 32'h30, 32'h0, "r30");
        check("r30_data", got_rdata, 32'hA5A50F0F);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h34; wdata = 32'h600DF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_w_ready", {31'h0, ready}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            if (k == 1) begin
                #1 we = 1'b0; be = 4'h0;
            end
            @(negedge clk);
            check($sformatf("held_r_ready%0d", k), {31'h0, ready}, {31'h0, k == 4});
        end
        check("held_r_data", rdata, 32'h600DF00D);
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1;
        access(1'b1, 4'hF, 32'h40, 32'h12345678, "w40");
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1 arstn = 1'b1; req = 1'b0; we = 1'b0;
        @(posedge clk);
        #1 arstn = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) pulses++;
        end
        check("rst_no_pulse", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 4'h0, 32'h40, 32'h0, "r40");
        check("r40_data", got_rdata, 32'h12345678);
        req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h8; wdata0 = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        check("z_w_ready", {31'h0, ready0}, 32'h1);
        @(posedge clk);
        #1 we0 = 1'b0; be0 = 4'h0;
        @(negedge clk);
        check("z_w_gap", {31'h0, ready0}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("z_r_ready", {31'h0, ready0}, 32'h1);
        check("z_r_data", rdata0, 32'h0BADF00D);
        check("z_r_err", {31'h0, err0}, 32'h0);
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        check("z_idle", {31'h0, ready0}, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
